fmap_stream_reader: RTL and testbench

//  Consumer end of the CNN engine output map. On a frame request, pulses the engine's reset and start,

---
 rtl/fmap_stream_reader_pkg.sv | 26 ++
 rtl/fmap_stream_reader_if.sv | 31 +++
 rtl/fmap_stream_reader_max4_signed.sv | 23 ++
 rtl/fmap_stream_reader.sv | 198 +++++++++++++++++++
 tb/tb_fmap_stream_reader.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_stream_reader_pkg.sv
// Shared definitions for the feature-map stream reader.
//   state_t      : reader FSM states
//   DEF_*        : default map geometry, word width and done timeout
//   POS_W        : width of the row/col fields carried with each beat
//   idx_w()      : index width needed to address n items (minimum 1)
package fmap_stream_reader_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_FMAP_W      = 6;
  localparam int unsigned DEF_FMAP_H      = 6;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned POS_W           = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENG_RST,
    S_ENG_START,
    S_WAIT_DONE,
    S_STREAM
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Valid/ready beat stream carrying one feature-map value plus its position.
//   m_valid : beat valid (master)
//   m_ready : downstream accept (slave)
//   m_data  : signed map value
//   m_row   : output row index of the beat
//   m_col   : output column index of the beat
//   m_last  : final beat of the frame
interface fmap_stream_reader_if
  import fmap_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;
  logic [POS_W-1:0]         m_row;
  logic [POS_W-1:0]         m_col;
  logic                     m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );

endinterface

// File: rtl/fmap_stream_reader_max4_signed.sv
// Combinational signed maximum of four words; used for the 2x2 pooling window.
//   a, b, c, d : signed inputs
//   y          : largest input (ties resolve to any equal value)
module max4_signed #(
  parameter int unsigned DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] ab;
  logic signed [DATA_W-1:0] cd;

  always_comb begin
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    y  = (ab > cd) ? ab : cd;
  end

endmodule

// File: rtl/fmap_stream_reader.sv
// Consumer end of the CNN engine output map. A frame request resets and
// starts the engine, waits (bounded) for done, then streams the map row-major
// over a valid/ready interface, optionally max-pooled 2x2/stride 2.
//   clk, rst   : clock; asynchronous active-high reset
//   frame_req  : one-cycle frame request, honoured only when idle
//   pool_en    : sampled with frame_req, selects pooled readout
//   eng_rst    : one-cycle engine reset pulse
//   eng_start  : one-cycle engine start pulse
//   eng_done   : engine done level, only looked at while waiting for it
//   fmap       : engine output map, row-major, read live while streaming
//   m          : beat stream (master side)
//   busy       : high whenever not idle
//   err        : sticky done-timeout flag, cleared by the next accepted request
//   frame_cnt  : completed frames, wrapping
module fmap_stream_reader
  import fmap_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FMAP_W      = DEF_FMAP_W,
  parameter int unsigned FMAP_H      = DEF_FMAP_H,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_req,
  input  logic                                   pool_en,
  output logic                                   eng_rst,
  output logic                                   eng_start,
  input  logic                                   eng_done,
  input  logic [FMAP_W*FMAP_H-1:0][DATA_W-1:0]   fmap,
  fmap_stream_reader_if.master                   m,
  output logic                                   busy,
  output logic                                   err,
  output logic [15:0]                            frame_cnt
);

  localparam int unsigned N  = FMAP_W * FMAP_H;
  localparam int unsigned AW = idx_w(N);
  localparam int unsigned TW = idx_w(TIMEOUT_CYC);

  state_t state;
  state_t state_nx;

  logic                     pool_q;
  logic [TW-1:0]            tcnt;
  logic                     tc_hit;

  // Position of the next beat to load into the output register.
  logic [POS_W-1:0]         row;
  logic [POS_W-1:0]         col;
  logic [POS_W-1:0]         row_last;
  logic [POS_W-1:0]         col_last;

  // Output register.
  logic                     v_q;
  logic signed [DATA_W-1:0] d_q;
  logic [POS_W-1:0]         r_q;
  logic [POS_W-1:0]         c_q;
  logic                     l_q;

  logic                     xfer;
  logic                     done_frame;
  logic                     load;

  int unsigned              ri;
  int unsigned              ci;
  logic [AW-1:0]            i_norm;
  logic [AW-1:0]            i00;
  logic [AW-1:0]            i01;
  logic [AW-1:0]            i10;
  logic [AW-1:0]            i11;
  logic signed [DATA_W-1:0] pool_val;
  logic signed [DATA_W-1:0] beat_val;

  assign tc_hit     = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign row_last   = pool_q ? POS_W'(FMAP_H/2 - 1) : POS_W'(FMAP_H - 1);
  assign col_last   = pool_q ? POS_W'(FMAP_W/2 - 1) : POS_W'(FMAP_W - 1);
  assign xfer       = v_q & m.m_ready;
  assign done_frame = xfer & l_q;
  // The register refills when empty or when its beat leaves, except once the
  // final beat is in it: that transfer ends the frame instead.
  assign load       = (state == S_STREAM) && (!v_q || (m.m_ready && !l_q));

  // Element addresses for the current position: direct, and the top-left
  // corner of the 2x2 window plus its three neighbours.
  always_comb begin
    ri     = 32'(row);
    ci     = 32'(col);
    i_norm = AW'(ri * FMAP_W + ci);
    i00    = AW'(2 * ri * FMAP_W + 2 * ci);
    i01    = i00 + AW'(1);
    i10    = i00 + AW'(FMAP_W);
    i11    = i10 + AW'(1);
  end

  max4_signed #(
    .DATA_W (DATA_W)
  ) u_max4 (
    .a (fmap[i00]),
    .b (fmap[i01]),
    .c (fmap[i10]),
    .d (fmap[i11]),
    .y (pool_val)
  );

  assign beat_val = pool_q ? pool_val : $signed(fmap[i_norm]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (frame_req) state_nx = S_ENG_RST;
      S_ENG_RST:   state_nx = S_ENG_START;
      S_ENG_START: state_nx = S_WAIT_DONE;
      // Done has priority over the terminal count in the same cycle.
      S_WAIT_DONE: begin
        if (eng_done)    state_nx = S_STREAM;
        else if (tc_hit) state_nx = S_IDLE;
      end
      S_STREAM:    if (done_frame) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_q    <= 1'b0;
      err       <= 1'b0;
      tcnt      <= '0;
      row       <= '0;
      col       <= '0;
      v_q       <= 1'b0;
      d_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      l_q       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_req) begin
            pool_q <= pool_en;
            err    <= 1'b0;
          end
        end
        S_ENG_START: begin
          tcnt <= '0;
          row  <= '0;
          col  <= '0;
        end
        S_WAIT_DONE: begin
          if (!eng_done) begin
            if (tc_hit) err  <= 1'b1;
            else        tcnt <= tcnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (done_frame) begin
            v_q       <= 1'b0;
            l_q       <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
          end else if (load) begin
            v_q <= 1'b1;
            d_q <= beat_val;
            r_q <= row;
            c_q <= col;
            l_q <= (row == row_last) && (col == col_last);
            if (col == col_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_rst   = (state == S_ENG_RST);
  assign eng_start = (state == S_ENG_START);
  assign busy      = (state != S_IDLE);

  assign m.m_valid = v_q;
  assign m.m_data  = d_q;
  assign m.m_row   = r_q;
  assign m.m_col   = c_q;
  assign m.m_last  = l_q;

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Scoreboard bench for fmap_stream_reader: frames are requested with directed
// maps, expected beats are queued up front and a negedge monitor pops and
// compares every transferred beat, and checks stall stability.
module tb_fmap_stream_reader;

  localparam int DW = 32;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int TO = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          last;
  } beat_t;

  logic clk;
  logic rst;
  logic frame_req;
  logic pool_en;
  logic eng_rst;
  logic eng_start;
  logic eng_done;
  logic busy;
  logic err;
  logic [15:0] frame_cnt;
  logic [N-1:0][DW-1:0] fmap_in;

  fmap_stream_reader_if #(.DATA_W(DW)) s_if ();

  fmap_stream_reader #(
    .DATA_W      (DW),
    .FMAP_W      (W),
    .FMAP_H      (H),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_req (frame_req),
    .pool_en   (pool_en),
    .eng_rst   (eng_rst),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .fmap      (fmap_in),
    .m         (s_if),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    beats_frame;
  int    n_rst_cyc;
  int    n_start_cyc;
  int    n_wait_cyc;
  time   first_valid_t;
  time   done_t;
  bit    rand_ready;
  bit    eng_hang;
  int    eng_delay;
  logic  err_after_req;
  int    pool_exp [9] = '{-11, -9, -7, 1, 3, 5, 13, 15, 17};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Engine stand-in: done rises eng_delay cycles after start, held until eng_rst.
  initial begin
    int cnt;
    eng_done = 1'b0;
    done_t   = 0;
    cnt      = -1;
    forever begin
      @(negedge clk);
      if (eng_rst) begin
        eng_done = 1'b0;
        cnt      = -1;
      end else if (eng_start) begin
        cnt = eng_delay;
      end else if (cnt > 0) begin
        cnt--;
      end else if (cnt == 0) begin
        cnt = -1;
        if (!eng_hang) begin
          eng_done = 1'b1;
          done_t   = $time;
        end
      end
    end
  end

  // Downstream ready: always on, or a coin flip per cycle.
  initial begin
    s_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic  pv;
    beat_t pb;
    beat_t got;
    beat_t e;
    pv = 1'b0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        n_rst_cyc   += int'(eng_rst);
        n_start_cyc += int'(eng_start);
        if (busy && !eng_rst && !eng_start) n_wait_cyc++;
        got.data = s_if.m_data;
        got.row  = s_if.m_row;
        got.col  = s_if.m_col;
        got.last = s_if.m_last;
        if (pv) begin
          check("stall_valid", 64'(s_if.m_valid), 1);
          check("stall_data", $signed(got.data), $signed(pb.data));
          check("stall_pos", 64'({got.row, got.col, got.last}),
                64'({pb.row, pb.col, pb.last}));
        end
        pv = s_if.m_valid && !s_if.m_ready;
        pb = got;
        if (s_if.m_valid && beats_frame == 0 && first_valid_t == 0)
          first_valid_t = $time;
        if (s_if.m_valid && s_if.m_ready) begin
          beats_frame++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", $signed(got.data), $signed(e.data));
            check("beat_row", 64'(got.row), 64'(e.row));
            check("beat_col", 64'(got.col), 64'(e.col));
            check("beat_last", 64'(got.last), 64'(e.last));
          end
        end
      end
    end
  end

  task automatic push_normal();
    beat_t b;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        b.data = fmap_in[r*W + c];
        b.row  = 3'(r);
        b.col  = 3'(c);
        b.last = (r == H-1) && (c == W-1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic push_pool();
    beat_t b;
    for (int i = 0; i < 9; i++) begin
      b.data = 32'(pool_exp[i]);
      b.row  = 3'(i / 3);
      b.col  = 3'(i % 3);
      b.last = (i == 8);
      exp_q.push_back(b);
    end
  endtask

  task automatic load_map1();
    for (int i = 0; i < N; i++) fmap_in[i] = 32'(i - 18);
  endtask

  task automatic run_frame(input bit pool, input bit midreq);
    bit pulsed;
    pulsed        = 1'b0;
    beats_frame   = 0;
    n_rst_cyc     = 0;
    n_start_cyc   = 0;
    n_wait_cyc    = 0;
    first_valid_t = 0;
    @(posedge clk); #1;
    frame_req = 1'b1;
    pool_en   = pool;
    @(posedge clk); #1;
    frame_req     = 1'b0;
    pool_en       = !pool;
    err_after_req = err;
    for (int k = 0; k < 3000 && busy; k++) begin
      @(posedge clk); #1;
      frame_req = 1'b0;
      if (midreq && !pulsed && beats_frame >= 5) begin
        frame_req = 1'b1;
        pulsed    = 1'b1;
      end
    end
    frame_req = 1'b0;
    check("frame_ends", 64'(busy), 0);
  endtask

  task automatic check_frame(input int beats, input int fcnt);
    check("beats_in_frame", beats_frame, beats);
    check("queue_empty", exp_q.size(), 0);
    check("frame_cnt", 64'(frame_cnt), fcnt);
    check("eng_rst_cycles", n_rst_cyc, 1);
    check("eng_start_cycles", n_start_cyc, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_valid"}, 64'(s_if.m_valid), 0);
    check({tag, "_m_last"}, 64'(s_if.m_last), 0);
    check({tag, "_m_data"}, 64'(s_if.m_data), 0);
    check({tag, "_m_pos"}, 64'({s_if.m_row, s_if.m_col}), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 0);
    check({tag, "_eng_pulses"}, 64'({eng_rst, eng_start}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_busy;
    rst           = 1'b1;
    frame_req     = 1'b0;
    pool_en       = 1'b0;
    rand_ready    = 1'b0;
    eng_hang      = 1'b0;
    eng_delay     = 3;
    beats_frame   = 0;
    n_rst_cyc     = 0;
    n_start_cyc   = 0;
    n_wait_cyc    = 0;
    first_valid_t = 0;
    load_map1();
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: plain readout of i-18.
    push_normal();
    run_frame(1'b0, 1'b0);
    check_frame(36, 1);

    // 2: pooled readout of the same map.
    push_pool();
    run_frame(1'b1, 1'b0);
    check_frame(9, 2);

    // 3: random back-pressure, plain then pooled.
    rand_ready = 1'b1;
    for (int i = 0; i < N; i++)
      fmap_in[i] = (i % 2 == 1) ? 32'(-(i*1000 + 7)) : 32'(i*3 + 5);
    push_normal();
    run_frame(1'b0, 1'b0);
    check_frame(36, 3);
    load_map1();
    push_pool();
    run_frame(1'b1, 1'b0);
    check_frame(9, 4);
    rand_ready = 1'b0;

    // 4: engine never finishes.
    eng_hang = 1'b1;
    run_frame(1'b0, 1'b0);
    eng_hang = 1'b0;
    check("timeout_err", 64'(err), 1);
    check("timeout_wait_cycles", n_wait_cyc, TO);
    check_frame(0, 4);

    // 5: request during streaming is dropped; stale done does not restart.
    push_normal();
    run_frame(1'b0, 1'b1);
    check("err_cleared_by_req", 64'(err_after_req), 0);
    check_frame(36, 5);
    idle_busy   = 0;
    beats_frame = 0;
    repeat (10) begin
      @(negedge clk);
      idle_busy += int'(busy);
    end
    check("idle_after_midreq_busy", idle_busy, 0);
    check("idle_after_midreq_beats", beats_frame, 0);
    eng_delay = 8;
    push_normal();
    run_frame(1'b0, 1'b0);
    check("valid_after_done", 64'(first_valid_t > done_t), 1);
    check_frame(36, 6);

    // 6: reset in the middle of a frame, then a clean frame.
    push_normal();
    beats_frame = 0;
    @(posedge clk); #1;
    frame_req = 1'b1;
    pool_en   = 1'b0;
    @(posedge clk); #1;
    frame_req = 1'b0;
    for (int k = 0; k < 500 && beats_frame < 10; k++) begin
      @(posedge clk); #1;
    end
    check("reached_beat10", beats_frame, 10);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("midframe_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_normal();
    run_frame(1'b0, 1'b0);
    check_frame(36, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
